// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter slice: default word and
//   address widths of the RISC-V core, the port identifier used to tag the
//   owner of an outstanding read, and a helper that sizes the fairness counter.
//
//   Contents:
//     RV_NB_WORD        default data word width (bits)
//     RV_NB_ADDR        default byte address width (bits)
//     ARB_MAX_WAIT_DEF  default number of losses port 1 tolerates
//     arb_port_t        {ARB_P0, ARB_P1} requester identifier
//     arb_cnt_width()   width of a counter that must reach max_wait
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int unsigned RV_NB_WORD       = 32;
  localparam int unsigned RV_NB_ADDR       = 32;
  localparam int unsigned ARB_MAX_WAIT_DEF = 3;

  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_port_t;

  // A counter saturating at max_wait needs $clog2(max_wait+1) bits. When
  // max_wait is 0 that evaluates to 0, so keep one bit to avoid a zero-width
  // vector; the counter then simply never leaves 0.
  function automatic int unsigned arb_cnt_width(input int unsigned max_wait);
    int unsigned w;
    w = $clog2(max_wait + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the memory-side port of the data
//   memory arbiter. Signal names keep the arbiter's point of view (i_* flow
//   into the arbiter, o_* flow out of it).
//
//   Requesters (port 0 = CPU load/store, port 1 = debug/loader):
//     i_pX_req, i_pX_wr, i_pX_addr, i_pX_wr_data   request side
//     o_pX_gnt                                       accepted this cycle
//     o_pX_rvalid, o_pX_rd_data                      read return
//   Memory:
//     o_mem_en, o_mem_wr, o_mem_address, o_mem_wr_data
//     i_mem_rd_data (valid the cycle after a read strobe)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding logic (requesters plus memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NB_WORD = RV_NB_WORD,
  parameter int unsigned NB_ADDR = RV_NB_ADDR
);

  logic               i_p0_req;
  logic               i_p0_wr;
  logic [NB_ADDR-1:0] i_p0_addr;
  logic [NB_WORD-1:0] i_p0_wr_data;
  logic               o_p0_gnt;
  logic               o_p0_rvalid;
  logic [NB_WORD-1:0] o_p0_rd_data;

  logic               i_p1_req;
  logic               i_p1_wr;
  logic [NB_ADDR-1:0] i_p1_addr;
  logic [NB_WORD-1:0] i_p1_wr_data;
  logic               o_p1_gnt;
  logic               o_p1_rvalid;
  logic [NB_WORD-1:0] o_p1_rd_data;

  logic               o_mem_en;
  logic               o_mem_wr;
  logic [NB_ADDR-1:0] o_mem_address;
  logic [NB_WORD-1:0] o_mem_wr_data;
  logic [NB_WORD-1:0] i_mem_rd_data;

  modport slave (
    input  i_p0_req, i_p0_wr, i_p0_addr, i_p0_wr_data,
    input  i_p1_req, i_p1_wr, i_p1_addr, i_p1_wr_data,
    input  i_mem_rd_data,
    output o_p0_gnt, o_p0_rvalid, o_p0_rd_data,
    output o_p1_gnt, o_p1_rvalid, o_p1_rd_data,
    output o_mem_en, o_mem_wr, o_mem_address, o_mem_wr_data
  );

  modport master (
    output i_p0_req, i_p0_wr, i_p0_addr, i_p0_wr_data,
    output i_p1_req, i_p1_wr, i_p1_addr, i_p1_wr_data,
    output i_mem_rd_data,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rd_data,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rd_data,
    input  o_mem_en, o_mem_wr, o_mem_address, o_mem_wr_data
  );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of the single-ported data memory. Port 0 (CPU
//   load/store) has priority; port 1 (debug/loader) is forced through after
//   MAX_WAIT consecutive losses so it can never starve. Grants are
//   combinational, one access per cycle, and a read's data returns on the
//   owning port one cycle after its grant.
//
//   Parameters:
//     NB_WORD   data word width
//     NB_ADDR   byte address width
//     MAX_WAIT  consecutive losses port 1 tolerates before it is forced to win
//
//   Ports:
//     i_clock   single clock
//     i_reset   synchronous, active-high
//     bus       dmem_arbiter_if.slave: requester ports and memory port
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NB_WORD  = RV_NB_WORD,
  parameter int unsigned NB_ADDR  = RV_NB_ADDR,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT_DEF
)(
  input  logic          i_clock,
  input  logic          i_reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = arb_cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]   wait_cnt;

  logic               p1_wins;
  logic               gnt0;
  logic               gnt1;
  arb_port_t          winner;
  logic               mem_en;
  logic               mem_wr;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_WORD-1:0] mem_wr_data;
  logic               rd_gnt;

  logic               rd_vld_p1;
  arb_port_t          rd_own_p1;

  // ---------------------------------------------------------------------------
  // Stage p0: combinational arbitration and memory request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // Port 1 takes the slot when port 0 is idle, or when it has already lost
    // MAX_WAIT times in a row. Reset masks both grants so nothing reaches
    // the memory while the arbiter is being initialised.
    p1_wins = bus.i_p1_req && (!bus.i_p0_req || (wait_cnt == WAIT_SAT));
    gnt1    = !i_reset && p1_wins;
    gnt0    = !i_reset && bus.i_p0_req && !p1_wins;
    winner  = gnt1 ? ARB_P1 : ARB_P0;
    mem_en  = gnt0 || gnt1;

    // Idle cycles drive zeros rather than holding the last request, which
    // keeps the memory bus quiet and easy to read in traces.
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (gnt1) begin
      mem_wr      = bus.i_p1_wr;
      mem_addr    = bus.i_p1_addr;
      mem_wr_data = bus.i_p1_wr_data;
    end else if (gnt0) begin
      mem_wr      = bus.i_p0_wr;
      mem_addr    = bus.i_p0_addr;
      mem_wr_data = bus.i_p0_wr_data;
    end

    rd_gnt = mem_en && !mem_wr;
  end

  assign bus.o_p0_gnt      = gnt0;
  assign bus.o_p1_gnt      = gnt1;
  assign bus.o_mem_en      = mem_en;
  assign bus.o_mem_wr      = mem_wr;
  assign bus.o_mem_address = mem_addr;
  assign bus.o_mem_wr_data = mem_wr_data;

  // Fairness counter: counts consecutive cycles in which port 1 asked and
  // lost. Any cycle where port 1 is served or stops asking starts it over.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wait_cnt <= '0;
    end else if (!bus.i_p1_req || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: read-return ownership (memory data arrives this cycle)
  // ---------------------------------------------------------------------------
  // Memory latency is exactly one cycle and only one access is issued per
  // cycle, so a single owner/valid entry covers back-to-back reads from either
  // port. The owner tag is only meaningful while rd_vld_p1 is set, so it is
  // left out of reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_gnt;
    end
    rd_own_p1 <= winner;
  end

  assign bus.o_p0_rvalid  = rd_vld_p1 && (rd_own_p1 == ARB_P0);
  assign bus.o_p1_rvalid  = rd_vld_p1 && (rd_own_p1 == ARB_P1);

  // Both ports see the raw memory data; rvalid alone says whose it is.
  assign bus.o_p0_rd_data = bus.i_mem_rd_data;
  assign bus.o_p1_rd_data = bus.i_mem_rd_data;

  // Structural invariants of the arbiter.
  a_gnt_exclusive : assert property (
    @(posedge i_clock) disable iff (i_reset) !(gnt0 && gnt1));
  a_gnt_needs_req : assert property (
    @(posedge i_clock) disable iff (i_reset)
      (!gnt0 || bus.i_p0_req) && (!gnt1 || bus.i_p1_req));
  a_rvalid_exclusive : assert property (
    @(posedge i_clock) disable iff (i_reset)
      !(bus.o_p0_rvalid && bus.o_p1_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: directed scenarios followed by
//   randomized traffic, all compared against a behavioural model that tracks
//   port 1's loss count as a plain integer and outstanding reads as an
//   expected (owner, address) record.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned NW = 32;
  localparam int unsigned NA = 32;
  localparam int          MW = 3;

  logic        clk;
  logic        rst;
  logic [31:0] mem_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          losses   = 0;
  bit          pend_vld = 1'b0;
  bit          pend_own = 1'b0;
  logic [31:0] pend_addr = '0;
  bit          exp_g0, exp_g1;

  // Inputs currently applied
  bit          c_rst, c_q0, c_w0, c_q1, c_w1;
  logic [31:0] c_a0, c_d0, c_a1, c_d1;

  dmem_arbiter_if #(.NB_WORD(NW), .NB_ADDR(NA)) bus ();

  dmem_arbiter #(.NB_WORD(NW), .NB_ADDR(NA), .MAX_WAIT(MW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  assign bus.i_mem_rd_data = mem_rd_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // One-cycle-latency memory; returns noise when nothing was read.
  always @(posedge clk)
    mem_rd_data <= (bus.o_mem_en && !bus.o_mem_wr) ? mem_f(bus.o_mem_address) : $urandom();

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r,
                       input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    c_rst = r; c_q0 = q0; c_w0 = w0; c_a0 = a0; c_d0 = d0;
    c_q1 = q1; c_w1 = w1; c_a1 = a1; c_d1 = d1;
    rst              = r;
    bus.i_p0_req     = q0;
    bus.i_p0_wr      = w0;
    bus.i_p0_addr    = a0;
    bus.i_p0_wr_data = d0;
    bus.i_p1_req     = q1;
    bus.i_p1_wr      = w1;
    bus.i_p1_addr    = a1;
    bus.i_p1_wr_data = d1;
    exp_g1 = !r && q1 && (!q0 || losses == MW);
    exp_g0 = !r && q0 && !exp_g1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Compare everything against the model mid-cycle, then advance the model
  // across the next rising edge.
  task automatic step();
    bit          e_en, e_wr;
    logic [31:0] e_addr, e_data;
    @(negedge clk);
    e_en   = exp_g0 || exp_g1;
    e_wr   = exp_g1 ? c_w1 : (exp_g0 ? c_w0 : 1'b0);
    e_addr = exp_g1 ? c_a1 : (exp_g0 ? c_a0 : 32'h0);
    e_data = exp_g1 ? c_d1 : (exp_g0 ? c_d0 : 32'h0);
    check_eq("gnt0",     bus.o_p0_gnt,      exp_g0);
    check_eq("gnt1",     bus.o_p1_gnt,      exp_g1);
    check_eq("mem_en",   bus.o_mem_en,      e_en);
    check_eq("mem_wr",   bus.o_mem_wr,      e_wr);
    check_eq("mem_addr", bus.o_mem_address, e_addr);
    check_eq("mem_wdat", bus.o_mem_wr_data, e_data);
    check_eq("rvalid0",  bus.o_p0_rvalid,   pend_vld && !pend_own);
    check_eq("rvalid1",  bus.o_p1_rvalid,   pend_vld &&  pend_own);
    check_eq("rd_data0_raw", bus.o_p0_rd_data, mem_rd_data);
    check_eq("rd_data1_raw", bus.o_p1_rd_data, mem_rd_data);
    if (pend_vld)
      check_eq(pend_own ? "rd_data1" : "rd_data0",
               pend_own ? bus.o_p1_rd_data : bus.o_p0_rd_data, mem_f(pend_addr));
    @(posedge clk);
    if (c_rst) begin
      losses   = 0;
      pend_vld = 1'b0;
    end else begin
      if (!c_q1 || exp_g1) losses = 0;
      else if (losses < MW) losses++;
      pend_vld  = (exp_g0 && !c_w0) || (exp_g1 && !c_w1);
      pend_own  = exp_g1;
      pend_addr = exp_g1 ? c_a1 : c_a0;
    end
    #1;
  endtask

  // Both ports read continuously for n cycles; port 1 must win exactly on
  // every fourth cycle of the run (three losses, then forced through).
  task automatic contend(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 32'h0000_0400 + 32'(i * 4), '0, 1, 0, 32'h0000_0800, '0);
      check_eq($sformatf("%s_p1gnt_%0d", name, i), bus.o_p1_gnt, (i % 4) == 3);
      step();
    end
  endtask

  initial begin
    bit          hold1;
    bit          q1, w1;
    logic [31:0] a1, d1;

    // Reset with both ports asking: nothing may be granted.
    drive(1, 1, 0, 32'h40, '0, 1, 0, 32'h80, '0);
    step();
    drive(1, 1, 0, 32'h40, '0, 1, 0, 32'h80, '0);
    check_eq("rst_gnt0",   bus.o_p0_gnt, 1'b0);
    check_eq("rst_gnt1",   bus.o_p1_gnt, 1'b0);
    check_eq("rst_mem_en", bus.o_mem_en, 1'b0);
    step();
    idle();
    check_eq("rst_rvalid0", bus.o_p0_rvalid, 1'b0);
    check_eq("rst_rvalid1", bus.o_p1_rvalid, 1'b0);
    step();

    // Port 0 read at 0x100.
    drive(0, 1, 0, 32'h100, '0, 0, 0, '0, '0);
    check_eq("rd100_gnt0", bus.o_p0_gnt, 1'b1);
    check_eq("rd100_addr", bus.o_mem_address, 32'h100);
    step();
    idle();
    check_eq("rd100_rvalid0", bus.o_p0_rvalid, 1'b1);
    check_eq("rd100_data",    bus.o_p0_rd_data, 32'hDEAD_BEEF);
    check_eq("rd100_rvalid1", bus.o_p1_rvalid, 1'b0);
    step();

    // Port 1 write, port 0 idle.
    drive(0, 0, 0, '0, '0, 1, 1, 32'h200, 32'h1234_5678);
    check_eq("wr200_en",   bus.o_mem_en, 1'b1);
    check_eq("wr200_wr",   bus.o_mem_wr, 1'b1);
    check_eq("wr200_addr", bus.o_mem_address, 32'h200);
    check_eq("wr200_data", bus.o_mem_wr_data, 32'h1234_5678);
    step();
    idle();
    check_eq("wr200_rvalid0", bus.o_p0_rvalid, 1'b0);
    check_eq("wr200_rvalid1", bus.o_p1_rvalid, 1'b0);
    step();

    // P0 read then P1 read on consecutive cycles.
    drive(0, 1, 0, 32'h300, '0, 0, 0, '0, '0);
    step();
    drive(0, 0, 0, '0, '0, 1, 0, 32'h304, '0);
    check_eq("b2b_rvalid0_n1", bus.o_p0_rvalid, 1'b1);
    check_eq("b2b_data0_n1",   bus.o_p0_rd_data, mem_f(32'h300));
    step();
    idle();
    check_eq("b2b_rvalid1_n2", bus.o_p1_rvalid, 1'b1);
    check_eq("b2b_rvalid0_n2", bus.o_p0_rvalid, 1'b0);
    check_eq("b2b_data1_n2",   bus.o_p1_rd_data, mem_f(32'h304));
    step();

    // Continuous contention: P0,P0,P0,P1 repeating.
    contend("cont", 8);
    idle();
    step();

    // Reset in the cycle a P0 read would be granted; counter must restart.
    drive(0, 1, 0, 32'h500, '0, 1, 0, 32'h900, '0);
    step();
    drive(0, 1, 0, 32'h504, '0, 1, 0, 32'h900, '0);
    step();
    drive(1, 1, 0, 32'h508, '0, 1, 0, 32'h900, '0);
    check_eq("rstrd_gnt0", bus.o_p0_gnt, 1'b0);
    step();
    idle();
    check_eq("rstrd_rvalid0", bus.o_p0_rvalid, 1'b0);
    step();
    contend("after_rst", 4);

    // P1 loses twice, drops for a cycle, then contention restarts from zero.
    idle();
    step();
    drive(0, 1, 0, 32'h600, '0, 1, 0, 32'hA00, '0);
    step();
    drive(0, 1, 0, 32'h604, '0, 1, 0, 32'hA00, '0);
    step();
    drive(0, 1, 0, 32'h608, '0, 0, 0, '0, '0);
    check_eq("drop_gnt0", bus.o_p0_gnt, 1'b1);
    step();
    contend("after_drop", 4);

    // Randomized traffic. Port 1 normally holds a pending request until it is
    // granted, occasionally withdrawing it.
    hold1 = 1'b0;
    q1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    for (int n = 0; n < 3000; n++) begin
      bit          r, q0, w0;
      logic [31:0] a0, d0;
      r  = ($urandom_range(0, 63) == 0);
      q0 = ($urandom_range(0, 9) < 6);
      w0 = $urandom_range(0, 1);
      a0 = 32'($urandom_range(0, 4095)) << 2;
      d0 = $urandom();
      if (!(hold1 && $urandom_range(0, 7) != 0)) begin
        q1 = $urandom_range(0, 1);
        w1 = $urandom_range(0, 1);
        a1 = 32'($urandom_range(0, 4095)) << 2;
        d1 = $urandom();
      end
      drive(r, q0, w0, a0, d0, q1, w1, a1, d1);
      hold1 = q1 && !exp_g1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
